// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the sequential adder/subtractor (seq_add_sub):
//   - op encodings     : OP_ADD / OP_SUB
//   - FSM state codes  : S_IDLE / S_CALC / S_DONE
//   - cnt_width()      : chunk-counter width, clog2(NCHUNK) with a floor of 1
// -----------------------------------------------------------------------------
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A single-chunk configuration still needs a 1-bit counter to be declarable.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Purely combinational CHUNK-bit ripple-carry slice built from full-adder cells.
// Ports:
//   x, y  in  [CHUNK-1:0]  chunk operands
//   cin   in  1            carry in
//   sum   out [CHUNK-1:0]  chunk sum
//   cout  out 1            carry out of the most significant cell
// -----------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
      assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_add_sub.sv
// -----------------------------------------------------------------------------
// seq_add_sub
// Multi-cycle two's-complement adder/subtractor. Operands are summed CHUNK bits
// per clock through a registered carry; valid/ready handshake on both sides.
// Optional build macro: ADDSUB_SATURATE_EN (clamp result on signed overflow;
// when undefined the result wraps modulo 2^WIDTH).
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/op presented
//   in_ready   out  high while idle (operation can be accepted)
//   a, b       in   [WIDTH-1:0] operands
//   op         in   0 = A+B, 1 = A-B
//   out_valid  out  result and flags valid (held until out_ready)
//   out_ready  in   consumer takes result
//   result     out  [WIDTH-1:0] sum/difference
//   carry_out  out  final carry (subtract: 1 = no borrow)
//   overflow   out  signed overflow
//   zero       out  result == 0
//   negative   out  result MSB
// -----------------------------------------------------------------------------
module seq_add_sub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam int MSB    = WIDTH - 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  // Operand chunks as arrays so the single slice can be muxed by cnt_q.
  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] raw_upd;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunks[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_q[gi*CHUNK +: CHUNK];
      // Raw result with the current chunk replaced by this cycle's sum.
      assign raw_upd[gi*CHUNK +: CHUNK] =
        (cnt_q == CW'(gi)) ? slice_sum : raw_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  addsub_chunk #(.CHUNK(CHUNK)) u_slice (
    .x    (a_chunks[cnt_q]),
    .y    (b_chunks[cnt_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  logic             last_chunk;
  logic             ovf_calc;
  logic [WIDTH-1:0] final_val;

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));
  // b_q already holds ~b for subtract, so this is the usual same-sign test.
  assign ovf_calc   = (a_q[MSB] == b_q[MSB]) && (raw_upd[MSB] != a_q[MSB]);

`ifdef ADDSUB_SATURATE_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val   = a_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
  assign final_val = ovf_calc ? sat_val : raw_upd;
`else
  assign final_val = raw_upd;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    raw_d   = raw_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          carry_d = (op != OP_ADD);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        raw_d   = raw_upd;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          state_d = S_DONE;
          res_d   = final_val;
          cout_d  = slice_cout;
          ovf_d   = ovf_calc;
          zero_d  = (final_val == '0);
          neg_d   = final_val[MSB];
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// -----------------------------------------------------------------------------
// tb_seq_add_sub
// Self-checking bench for seq_add_sub (WIDTH=6, CHUNK=2). Expected values come
// from a plain-integer arithmetic model. Define ADDSUB_SATURATE_EN when
// compiling to check the saturating build.
// -----------------------------------------------------------------------------
module tb_seq_add_sub;

  localparam int W      = 6;
  localparam int C      = 2;
  localparam int NCHUNK = W / C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero, negative;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_r;
  logic         exp_c, exp_o, exp_z, exp_n;

  seq_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic opv, output logic [W-1:0] r,
                                output logic c, output logic ov,
                                output logic z, output logic n);
    int ua, ub, sa, sb, ss, ur;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 32) ? ua - 64 : ua;
    sb = (ub >= 32) ? ub - 64 : ub;
    if (!opv) begin
      ur = ua + ub;
      c  = (ur >= 64);
      ss = sa + sb;
    end else begin
      ur = ua - ub;
      c  = (ua >= ub);
      ss = sa - sb;
    end
    ur = (ur + 128) % 64;
    ov = (ss > 31) || (ss < -32);
`ifdef ADDSUB_SATURATE_EN
    if (ov) ur = (ss > 31) ? 31 : 32;
`endif
    r = W'(ur);
    z = (ur == 0);
    n = (ur >= 32);
  endfunction

  // Called at a negedge with the DUT idle. Returns at a negedge: idle again if
  // out_ready is high, otherwise still in DONE.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic opv, input string tag);
    int lat;
    model(av, bv, opv, exp_r, exp_c, exp_o, exp_z, exp_n);
    a        = av;
    b        = bv;
    op       = opv;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    op       = 1'($urandom);
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk({tag, "_busy"}, 32'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"},  32'(lat),       NCHUNK);
    chk({tag, "_result"},   32'(result),    32'(exp_r));
    chk({tag, "_carry"},    32'(carry_out), 32'(exp_c));
    chk({tag, "_overflow"}, 32'(overflow),  32'(exp_o));
    chk({tag, "_zero"},     32'(zero),      32'(exp_z));
    chk({tag, "_negative"}, 32'(negative),  32'(exp_n));
    $display("op %s: a=%0d b=%0d op=%0d -> result=%b c=%0d v=%0d z=%0d n=%0d lat=%0d",
             tag, av, bv, opv, result, carry_out, overflow, zero, negative, lat);
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] na, nb;
    logic         nop;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result",    32'(result),    0);
    chk("rst_flags",     32'({carry_out, overflow, zero, negative}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(6'd5,  6'd9,  1'b0, "add_5_9");
    do_op(6'd12, 6'd20, 1'b1, "sub_12_20");
    do_op(6'd31, 6'd1,  1'b0, "ovf_31_p1");
`ifdef ADDSUB_SATURATE_EN
    chk("sat_31_p1_value", 32'(result), 32'h1f);
`else
    chk("wrap_31_p1_value", 32'(result), 32'h20);
`endif
    do_op(6'd32, 6'd1,  1'b1, "ovf_m32_m1");
    do_op(6'd17, 6'd17, 1'b1, "sub_17_17");
    do_op(6'd0,  6'd32, 1'b1, "sub_0_m32");

    // Random ops
    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // Backpressure: hold DONE while new operands are offered
    out_ready = 1'b0;
    do_op(6'd10, 6'd3, 1'b0, "bp");
    na       = W'($urandom);
    nb       = W'($urandom);
    nop      = 1'($urandom);
    a        = na;
    b        = nb;
    op       = nop;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready",  32'(in_ready),  0);
      chk("bp_result",    32'(result),    32'(exp_r));
      chk("bp_flags",     32'({carry_out, overflow, zero, negative}),
                          32'({exp_c, exp_o, exp_z, exp_n}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 0);
    chk("bp_release_in_ready",  32'(in_ready),  1);
    do_op(na, nb, nop, "bp_next");

    // Reset during the second CALC cycle
    a        = 6'd20;
    b        = 6'd7;
    op       = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_result",    32'(result),    0);
    chk("midrst_in_ready",  32'(in_ready),  1);
    chk("midrst_flags",     32'({carry_out, overflow, zero, negative}), 0);
    $display("reset asserted mid-CALC: result=%b out_valid=%0d", result, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_no_valid", 32'(out_valid), 0);
    end
    do_op(6'd3, 6'd4, 1'b0, "after_rst_3_4");
    chk("after_rst_value", 32'(result), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
